// File: rtl/ir_nec_pkg.sv
// Shared definitions for the NEC IR receiver: FSM state encodings and the
// accepted mark/space width windows, all expressed in measurement ticks.
package ir_nec_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_LEAD_MARK  = 3'd1;
    localparam logic [2:0] ST_LEAD_SPACE = 3'd2;
    localparam logic [2:0] ST_BIT_MARK   = 3'd3;
    localparam logic [2:0] ST_BIT_SPACE  = 3'd4;
    localparam logic [2:0] ST_END_MARK   = 3'd5;
    localparam logic [2:0] ST_REP_MARK   = 3'd6;

    // Inclusive windows; a 10 us tick makes 900 ticks the nominal 9 ms leader.
    localparam logic [15:0] LEAD_MARK_MIN  = 16'd800;
    localparam logic [15:0] LEAD_MARK_MAX  = 16'd1000;
    localparam logic [15:0] LEAD_SPACE_MIN = 16'd400;
    localparam logic [15:0] LEAD_SPACE_MAX = 16'd500;
    localparam logic [15:0] REP_SPACE_MIN  = 16'd180;
    localparam logic [15:0] REP_SPACE_MAX  = 16'd270;
    localparam logic [15:0] BIT_MARK_MIN   = 16'd40;
    localparam logic [15:0] BIT_MARK_MAX   = 16'd70;
    localparam logic [15:0] ZERO_SPACE_MIN = 16'd40;
    localparam logic [15:0] ZERO_SPACE_MAX = 16'd70;
    localparam logic [15:0] ONE_SPACE_MIN  = 16'd140;
    localparam logic [15:0] ONE_SPACE_MAX  = 16'd200;

    function automatic logic in_window(input logic [15:0] w,
                                       input logic [15:0] lo,
                                       input logic [15:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

endpackage

// File: rtl/ir_edge_sync.sv
// Two-flop synchroniser for the asynchronous IR line plus a delay flop that
// turns level changes into single-cycle rise/fall pulses.
module ir_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic dly;

    // Reset to 1 so an idle (high) line produces no edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            dly   <= 1'b1;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            dly   <= sync2;
        end
    end

    assign rise = sync2 & ~dly;
    assign fall = ~sync2 & dly;

endmodule

// File: rtl/ir_nec_rx_ctrl.sv
// NEC IR frame decoder: measures mark/space widths in prescaled ticks, walks
// leader/32 data bits/stop, and presents address/command with a ready handshake.
module ir_nec_rx_ctrl
    import ir_nec_pkg::*;
#(
    parameter int TICK_DIV = 120,
    parameter int CNT_W    = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ir_in,
    input  logic       rd_clr,
    output logic       frame_rdy,
    output logic       ovr,
    output logic [7:0] addr,
    output logic [7:0] addr_n,
    output logic [7:0] cmd,
    output logic       rpt,
    output logic       err,
    output logic       busy
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             mark_start;
    logic             mark_end;
    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    logic [CNT_W-1:0] width_cnt;
    logic [15:0]      width;
    logic [2:0]       state, state_d;
    logic [4:0]       bit_idx, bit_idx_d;
    logic [31:0]      shreg, shreg_d;
    logic             err_d, rpt_d, load_d;
    logic             have_frame;

    // Line idles high; a falling edge is the start of a carrier burst (mark).
    ir_edge_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ir_in),
        .rise  (mark_end),
        .fall  (mark_start)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pre_cnt <= '0;
        else if (pre_cnt == PRE_LAST)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + 1'b1;
    end

    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            width_cnt <= '0;
        else if (mark_start || mark_end)
            width_cnt <= '0;
        else if (tick && (width_cnt != CNT_MAX))
            width_cnt <= width_cnt + 1'b1;
    end

    assign width = 16'(width_cnt);
    assign busy  = (state != ST_IDLE);

    always_comb begin
        state_d   = state;
        bit_idx_d = bit_idx;
        shreg_d   = shreg;
        err_d     = 1'b0;
        rpt_d     = 1'b0;
        load_d    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mark_start) state_d = ST_LEAD_MARK;
            end
            ST_LEAD_MARK: begin
                if (mark_end) begin
                    if (in_window(width, LEAD_MARK_MIN, LEAD_MARK_MAX)) begin
                        state_d = ST_LEAD_SPACE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_LEAD_SPACE: begin
                if (mark_start) begin
                    if (in_window(width, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
                        state_d   = ST_BIT_MARK;
                        bit_idx_d = 5'd0;
                    end else if (in_window(width, REP_SPACE_MIN, REP_SPACE_MAX)) begin
                        state_d = ST_REP_MARK;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_BIT_MARK: begin
                if (mark_end) begin
                    if (in_window(width, BIT_MARK_MIN, BIT_MARK_MAX)) begin
                        state_d = ST_BIT_SPACE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            // Bits arrive LSB first, so shifting right leaves addr in [7:0].
            ST_BIT_SPACE: begin
                if (mark_start) begin
                    if (in_window(width, ZERO_SPACE_MIN, ZERO_SPACE_MAX) ||
                        in_window(width, ONE_SPACE_MIN, ONE_SPACE_MAX)) begin
                        shreg_d = {in_window(width, ONE_SPACE_MIN, ONE_SPACE_MAX),
                                   shreg[31:1]};
                        if (bit_idx == 5'd31) begin
                            state_d = ST_END_MARK;
                        end else begin
                            bit_idx_d = bit_idx + 5'd1;
                            state_d   = ST_BIT_MARK;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_END_MARK: begin
                if (mark_end) begin
                    if (in_window(width, BIT_MARK_MIN, BIT_MARK_MAX) &&
                        ((shreg[23:16] ^ shreg[31:24]) == 8'hFF)) begin
                        load_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            ST_REP_MARK: begin
                if (mark_end) begin
                    if (in_window(width, BIT_MARK_MIN, BIT_MARK_MAX) && have_frame)
                        rpt_d = 1'b1;
                    else
                        err_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A saturated counter means the line stalled; abandon the frame.
        if ((state != ST_IDLE) && !(mark_start || mark_end) && (width_cnt == CNT_MAX)) begin
            err_d   = 1'b1;
            rpt_d   = 1'b0;
            load_d  = 1'b0;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            bit_idx <= '0;
            shreg   <= '0;
            err     <= 1'b0;
            rpt     <= 1'b0;
        end else begin
            state   <= state_d;
            bit_idx <= bit_idx_d;
            shreg   <= shreg_d;
            err     <= err_d;
            rpt     <= rpt_d;
        end
    end

    // A load coinciding with rd_clr keeps the new frame ready and drops overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_rdy  <= 1'b0;
            ovr        <= 1'b0;
            addr       <= '0;
            addr_n     <= '0;
            cmd        <= '0;
            have_frame <= 1'b0;
        end else if (load_d) begin
            addr       <= shreg[7:0];
            addr_n     <= shreg[15:8];
            cmd        <= shreg[23:16];
            frame_rdy  <= 1'b1;
            have_frame <= 1'b1;
            if (rd_clr)
                ovr <= 1'b0;
            else if (frame_rdy)
                ovr <= 1'b1;
        end else if (rd_clr) begin
            frame_rdy <= 1'b0;
            ovr       <= 1'b0;
        end
    end

endmodule
